// File: rtl/rv_width_packer_if.sv
// Ready/valid bundle for the width packer: narrow input stream and wide output stream.
interface rv_width_packer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4
);
  logic [DATA_WIDTH-1:0]       input_port_data;
  logic                        input_port_valid;
  logic                        input_port_ready;
  logic [DATA_WIDTH*RATIO-1:0] output_port_data;
  logic                        output_port_valid;
  logic                        output_port_ready;

  modport slave (
    input  input_port_data,
    input  input_port_valid,
    output input_port_ready,
    output output_port_data,
    output output_port_valid,
    input  output_port_ready
  );

  modport master (
    output input_port_data,
    output input_port_valid,
    input  input_port_ready,
    input  output_port_data,
    input  output_port_valid,
    output output_port_ready
  );
endinterface

// File: rtl/rv_width_packer.sv
// Gathers RATIO narrow beats (little-endian) into one wide word behind a registered
// output slot; the last beat may load while the previous word drains, with no bubble.
module rv_width_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4
) (
  input  logic             clock_port,
  input  logic             reset_port,
  input  logic             clear,
  rv_width_packer_if.slave bus
);

  localparam int unsigned CW = $clog2(RATIO);
  localparam int unsigned AW = (RATIO - 1) * DATA_WIDTH;
  localparam int unsigned OW = DATA_WIDTH * RATIO;

  logic [AW-1:0] asm_q,       asm_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [OW-1:0] out_data_q,  out_data_d;
  logic          out_valid_q, out_valid_d;

  logic last_beat;
  logic in_ready;
  logic in_acc;
  logic out_acc;

  // The last beat needs the output slot free or draining in the same cycle.
  always_comb begin
    last_beat = (cnt_q == CW'(RATIO - 1));
    in_ready  = ~reset_port & ~clear & (~last_beat | ~out_valid_q | bus.output_port_ready);
    in_acc    = bus.input_port_valid & in_ready;
    out_acc   = out_valid_q & bus.output_port_ready;
  end

  always_comb begin
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_acc) begin
        out_valid_d = 1'b0;
      end
      if (in_acc) begin
        if (last_beat) begin
          out_data_d  = {bus.input_port_data, asm_q};
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          for (int unsigned i = 0; i < RATIO - 1; i++) begin
            if (cnt_q == CW'(i)) begin
              asm_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.input_port_data;
            end
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_port) begin
    if (reset_port) begin
      asm_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.input_port_ready  = in_ready;
  assign bus.output_port_data  = out_data_q;
  assign bus.output_port_valid = out_valid_q;

endmodule

// File: tb/tb_rv_width_packer.sv
// Directed bench for rv_width_packer (DATA_WIDTH=8, RATIO=4).
module tb_rv_width_packer;

  logic clk;
  logic rst;
  logic clr;
  int   n_checks;
  int   n_pass;

  rv_width_packer_if #(.DATA_WIDTH(8), .RATIO(4)) bus ();

  rv_width_packer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .clock_port (clk),
    .reset_port (rst),
    .clear      (clr),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive just after the rising edge, return at the falling edge for sampling.
  task automatic cyc(input logic r, input logic c, input logic v, input logic [7:0] d, input logic ordy);
    @(posedge clk);
    #1;
    rst                   = r;
    clr                   = c;
    bus.input_port_valid  = v;
    bus.input_port_data   = d;
    bus.output_port_ready = ordy;
    @(negedge clk);
  endtask

  task automatic chk_ready(input string name, input logic exp);
    n_checks++;
    if (bus.input_port_ready !== exp)
      $display("FAIL %s: input_port_ready got %b want %b", name, bus.input_port_ready, exp);
    else n_pass++;
  endtask

  task automatic chk_out(input string name, input logic exp_v, input logic [31:0] exp_d, input logic cmp_d);
    n_checks++;
    if (bus.output_port_valid !== exp_v)
      $display("FAIL %s: output_port_valid got %b want %b", name, bus.output_port_valid, exp_v);
    else n_pass++;
    if (cmp_d) begin
      n_checks++;
      if (bus.output_port_data !== exp_d)
        $display("FAIL %s: output_port_data got %h want %h", name, bus.output_port_data, exp_d);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1);
    chk_ready("reset_ready", 1'b0);
    chk_out("reset_out", 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_ready("reset_release_ready", 1'b1);
    chk_out("reset_release_out", 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_single();
    logic [7:0] beats [4];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, beats[i], 1'b1);
      chk_ready("single_ready", 1'b1);
      chk_out("single_idle", 1'b0, 32'h0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_ready("single_ready_after", 1'b1);
    chk_out("single_word", 1'b1, 32'h44332211, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("single_one_cycle", 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_stream();
    logic [31:0] words [4];
    words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
      chk_ready("stream_ready", 1'b1);
      if (i % 4 == 0 && i > 0) chk_out("stream_word", 1'b1, words[i/4 - 1], 1'b1);
      else                     chk_out("stream_gap", 1'b0, 32'h0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("stream_last_word", 1'b1, words[3], 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("stream_drained", 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] beats [4];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, beats[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
      chk_ready("bp_accept", 1'b1);
      chk_out("bp_hold", 1'b1, 32'h44332211, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'hA3, 1'b0);
      chk_ready("bp_stall", 1'b0);
      chk_out("bp_stall_hold", 1'b1, 32'h44332211, 1'b1);
    end
    cyc(1'b0, 1'b0, 1'b1, 8'hA3, 1'b1);
    chk_ready("bp_release", 1'b1);
    chk_out("bp_release_word", 1'b1, 32'h44332211, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_out("bp_next_word", 1'b1, 32'hA3A2A1A0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("bp_next_hold", 1'b1, 32'hA3A2A1A0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("bp_drained", 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_clear_partial();
    cyc(1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 8'h66, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
    chk_ready("clr_ready", 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
      chk_ready("clr_refill_ready", 1'b1);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("clr_word", 1'b1, 32'h04030201, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("clr_word_gone", 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_clear_pending();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'hB0 + 8'(i), 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_out("clrp_pending", 1'b1, 32'hB3B2B1B0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk_ready("clrp_ready", 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("clrp_dropped", 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("clrp_not_again", 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'hC0 + 8'(i), 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
    chk_ready("rstm_ready0", 1'b0);
    chk_out("rstm_valid0", 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
    chk_ready("rstm_ready1", 1'b0);
    chk_out("rstm_out1", 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'hD0 + 8'(i), 1'b1);
      chk_ready("rstm_refill_ready", 1'b1);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("rstm_word", 1'b1, 32'hD3D2D1D0, 1'b1);
  endtask

  initial begin
    n_checks              = 0;
    n_pass                = 0;
    rst                   = 1'b1;
    clr                   = 1'b0;
    bus.input_port_valid  = 1'b0;
    bus.input_port_data   = 8'h00;
    bus.output_port_ready = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_back_to_back();
    test_clear_partial();
    test_clear_pending();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
